// File: rtl/vga_sync_param_pkg.sv
// Default 640x480@60 timing constants and the total-period helper shared by
// the VGA sync generator and the picture generators below it.
package vga_timing_pkg;

    function automatic int calc_total(input int display, input int front,
                                      input int retrace, input int back);
        return display + front + retrace + back;
    endfunction

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_RETRACE = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_RETRACE = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_TICK_DIV  = 2;
    localparam int DEF_XY_W      = 10;
    localparam int DEF_FRAME_W   = 8;

    localparam int DEF_H_TOTAL = calc_total(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_RETRACE, DEF_H_BACK);
    localparam int DEF_V_TOTAL = calc_total(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_RETRACE, DEF_V_BACK);

endpackage

// File: rtl/vga_sync_param_if.sv
// Display-timing bundle between the sync generator (master) and the
// picture generators that consume coordinates and strobes (slave).
interface vga_sync_param_if #(
    parameter int XY_W    = 10,
    parameter int FRAME_W = 8
);
    logic               en;
    logic               p_tick;
    logic [XY_W-1:0]    pixel_x;
    logic [XY_W-1:0]    pixel_y;
    logic               hsync;
    logic               vsync;
    logic               video_on;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_count;

    modport master (
        input  en,
        output p_tick, pixel_x, pixel_y, hsync, vsync, video_on,
               line_start, frame_start, frame_count
    );

    modport slave (
        output en,
        input  p_tick, pixel_x, pixel_y, hsync, vsync, video_on,
               line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_sync_param_tick_div.sv
// Pixel-rate enable: divides clk by TICK_DIV while enabled; with TICK_DIV=1
// the tick simply follows the enable.
module pixel_tick_div #(
    parameter int TICK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    output logic o_p_tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_div_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (i_en) begin
            r_div_cnt <= (r_div_cnt == DIV_MAX) ? '0 : r_div_cnt + CNT_ONE;
        end
    end

    assign o_p_tick = i_en && (r_div_cnt == DIV_MAX);

endmodule

// File: rtl/vga_sync_param.sv
// Parametrised VGA sync / pixel-coordinate generator with pause, line and
// frame strobes and a free-running completed-frame counter.
module vga_sync_param
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_RETRACE = DEF_H_RETRACE,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_RETRACE = DEF_V_RETRACE,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int XY_W      = DEF_XY_W,
    parameter int FRAME_W   = DEF_FRAME_W
) (
    input  logic             clk,
    input  logic             reset,
    vga_sync_param_if.master bus
);
    localparam int H_TOTAL = calc_total(H_DISPLAY, H_FRONT, H_RETRACE, H_BACK);
    localparam int V_TOTAL = calc_total(V_DISPLAY, V_FRONT, V_RETRACE, V_BACK);

    localparam logic [XY_W-1:0]    H_LAST    = XY_W'(H_TOTAL - 1);
    localparam logic [XY_W-1:0]    V_LAST    = XY_W'(V_TOTAL - 1);
    localparam logic [XY_W-1:0]    H_VIS     = XY_W'(H_DISPLAY);
    localparam logic [XY_W-1:0]    V_VIS     = XY_W'(V_DISPLAY);
    localparam logic [XY_W-1:0]    HS_FIRST  = XY_W'(H_DISPLAY + H_FRONT);
    localparam logic [XY_W-1:0]    HS_LAST   = XY_W'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
    localparam logic [XY_W-1:0]    VS_FIRST  = XY_W'(V_DISPLAY + V_FRONT);
    localparam logic [XY_W-1:0]    VS_LAST   = XY_W'(V_DISPLAY + V_FRONT + V_RETRACE - 1);
    localparam logic [XY_W-1:0]    XY_ONE    = XY_W'(1);
    localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);

    logic               w_p_tick;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic [XY_W-1:0]    w_h_next;
    logic [XY_W-1:0]    w_v_next;
    logic [FRAME_W-1:0] w_frame_next;

    logic [XY_W-1:0]    r_h_cnt;
    logic [XY_W-1:0]    r_v_cnt;
    logic [FRAME_W-1:0] r_frame_count;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_video_on;

    function automatic logic in_window(input logic [XY_W-1:0] v,
                                       input logic [XY_W-1:0] first,
                                       input logic [XY_W-1:0] last);
        return (v >= first) && (v <= last);
    endfunction

    pixel_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk      (clk),
        .reset    (reset),
        .i_en     (bus.en),
        .o_p_tick (w_p_tick)
    );

    always_comb begin
        w_h_wrap     = (r_h_cnt == H_LAST);
        w_v_wrap     = (r_v_cnt == V_LAST);
        w_h_next     = w_h_wrap ? '0 : r_h_cnt + XY_ONE;
        w_v_next     = r_v_cnt;
        w_frame_next = r_frame_count;
        if (w_h_wrap) begin
            w_v_next = w_v_wrap ? '0 : r_v_cnt + XY_ONE;
            if (w_v_wrap) begin
                w_frame_next = r_frame_count + FRAME_ONE;
            end
        end
    end

    // Sync/blank flags decode the next counter values so they change on the
    // same edge as pixel_x/pixel_y instead of one pixel late.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_frame_count <= '0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_video_on    <= 1'b1;
        end else if (w_p_tick) begin
            r_h_cnt       <= w_h_next;
            r_v_cnt       <= w_v_next;
            r_frame_count <= w_frame_next;
            r_hsync       <= in_window(w_h_next, HS_FIRST, HS_LAST) ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= in_window(w_v_next, VS_FIRST, VS_LAST) ? VSYNC_POL : ~VSYNC_POL;
            r_video_on    <= (w_h_next < H_VIS) && (w_v_next < V_VIS);
        end
    end

    assign bus.p_tick      = w_p_tick;
    assign bus.pixel_x     = r_h_cnt;
    assign bus.pixel_y     = r_v_cnt;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.video_on    = r_video_on;
    assign bus.frame_count = r_frame_count;
    assign bus.line_start  = w_p_tick && (r_h_cnt == '0);
    assign bus.frame_start = w_p_tick && (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

// File: tb/tb_vga_sync_param.sv
// Bench for vga_sync_param: three geometries run side by side against an
// arithmetic model (outputs derived from the count of enabled clks since reset).
module tb_vga_sync_param;
    import vga_timing_pkg::*;

    typedef struct packed {
        int hd; int hf; int hr; int hb;
        int vd; int vf; int vr; int vb;
        int td; int fw; bit hp; bit vp;
    } geo_t;

    typedef struct packed {
        bit pt; bit hs; bit vs; bit von; bit ls; bit fs;
        int x; int y; int fc;
    } exp_t;

    localparam geo_t G_DEF = '{hd:640, hf:16, hr:96, hb:48, vd:480, vf:10, vr:2, vb:33,
                               td:2, fw:8, hp:1'b0, vp:1'b0};
    localparam geo_t G_SML = '{hd:8, hf:2, hr:2, hb:2, vd:4, vf:1, vr:1, vb:1,
                               td:1, fw:2, hp:1'b0, vp:1'b0};
    localparam geo_t G_MED = '{hd:64, hf:4, hr:8, hb:4, vd:48, vf:2, vr:2, vb:4,
                               td:2, fw:8, hp:1'b1, vp:1'b1};

    logic clk;
    logic rst_def, rst_sml, rst_med;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_def = 0;
    int   n_sml = 0;
    int   n_med = 0;

    vga_sync_param_if                              if_def ();
    vga_sync_param_if #(.XY_W(4), .FRAME_W(2))     if_sml ();
    vga_sync_param_if #(.XY_W(8), .FRAME_W(8))     if_med ();

    vga_sync_param u_def (.clk(clk), .reset(rst_def), .bus(if_def));

    vga_sync_param #(
        .H_DISPLAY(8), .H_FRONT(2), .H_RETRACE(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_RETRACE(1), .V_BACK(1),
        .TICK_DIV(1), .XY_W(4), .FRAME_W(2)
    ) u_sml (.clk(clk), .reset(rst_sml), .bus(if_sml));

    vga_sync_param #(
        .H_DISPLAY(64), .H_FRONT(4), .H_RETRACE(8), .H_BACK(4),
        .V_DISPLAY(48), .V_FRONT(2), .V_RETRACE(2), .V_BACK(4),
        .TICK_DIV(2), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .XY_W(8), .FRAME_W(8)
    ) u_med (.clk(clk), .reset(rst_med), .bus(if_med));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Enabled-clk counts since reset: the only state the model needs.
    always @(posedge clk or posedge rst_def) if (rst_def) n_def <= 0; else if (if_def.en) n_def <= n_def + 1;
    always @(posedge clk or posedge rst_sml) if (rst_sml) n_sml <= 0; else if (if_sml.en) n_sml <= n_sml + 1;
    always @(posedge clk or posedge rst_med) if (rst_med) n_med <= 0; else if (if_med.en) n_med <= n_med + 1;

    function automatic exp_t model(geo_t g, int n, logic en);
        exp_t e;
        int ht, vt, ticks, idx;
        ht    = g.hd + g.hf + g.hr + g.hb;
        vt    = g.vd + g.vf + g.vr + g.vb;
        ticks = n / g.td;
        idx   = ticks % (ht * vt);
        e.x   = idx % ht;
        e.y   = idx / ht;
        e.fc  = (ticks / (ht * vt)) % (1 << g.fw);
        e.pt  = en && ((n % g.td) == g.td - 1);
        e.hs  = (e.x >= g.hd + g.hf && e.x < g.hd + g.hf + g.hr) ? g.hp : !g.hp;
        e.vs  = (e.y >= g.vd + g.vf && e.y < g.vd + g.vf + g.vr) ? g.vp : !g.vp;
        e.von = (e.x < g.hd) && (e.y < g.vd);
        e.ls  = e.pt && (e.x == 0);
        e.fs  = e.ls && (e.y == 0);
        return e;
    endfunction

    task automatic cmp(string nm, exp_t e, exp_t a);
        total++;
        if (e !== a) begin
            bad++;
            $display("FAIL %s cyc=%0d got pt=%0b hs=%0b vs=%0b von=%0b ls=%0b fs=%0b x=%0d y=%0d fc=%0d want pt=%0b hs=%0b vs=%0b von=%0b ls=%0b fs=%0b x=%0d y=%0d fc=%0d",
                     nm, cyc, a.pt, a.hs, a.vs, a.von, a.ls, a.fs, a.x, a.y, a.fc,
                     e.pt, e.hs, e.vs, e.von, e.ls, e.fs, e.x, e.y, e.fc);
        end
    endtask

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t a;
        #1;
        a = '{pt:if_def.p_tick, hs:if_def.hsync, vs:if_def.vsync, von:if_def.video_on,
              ls:if_def.line_start, fs:if_def.frame_start, x:int'(if_def.pixel_x),
              y:int'(if_def.pixel_y), fc:int'(if_def.frame_count)};
        cmp("def_model", model(G_DEF, n_def, if_def.en), a);
        a = '{pt:if_sml.p_tick, hs:if_sml.hsync, vs:if_sml.vsync, von:if_sml.video_on,
              ls:if_sml.line_start, fs:if_sml.frame_start, x:int'(if_sml.pixel_x),
              y:int'(if_sml.pixel_y), fc:int'(if_sml.frame_count)};
        cmp("sml_model", model(G_SML, n_sml, if_sml.en), a);
        a = '{pt:if_med.p_tick, hs:if_med.hsync, vs:if_med.vsync, von:if_med.video_on,
              ls:if_med.line_start, fs:if_med.frame_start, x:int'(if_med.pixel_x),
              y:int'(if_med.pixel_y), fc:int'(if_med.frame_count)};
        cmp("med_model", model(G_MED, n_med, if_med.en), a);
    end

    task automatic run_def();
        int c, hs_cnt, hs_first, hs_last;
        c = 0;
        while (!if_def.p_tick && c < 10) begin @(negedge clk); c++; end
        chk("def_first_tick_cycle", c, 1);
        c = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
        do begin
            @(negedge clk); c++;
            if (if_def.p_tick && !if_def.hsync) begin
                if (hs_first < 0) hs_first = int'(if_def.pixel_x);
                hs_last = int'(if_def.pixel_x);
                hs_cnt++;
            end
        end while (!if_def.line_start && c < 4000);
        chk("def_line_clks", c, 1600);
        chk("def_hsync_ticks", hs_cnt, 96);
        chk("def_hsync_first_x", hs_first, 656);
        chk("def_hsync_last_x", hs_last, 751);

        c = 0;
        while (!(if_def.pixel_x == 10'd100 && if_def.pixel_y == 10'd20 && !if_def.p_tick) && c < 40000) begin
            @(negedge clk); c++;
        end
        chk("def_reach_100_20", int'(c < 40000), 1);
        if_def.en = 1'b0;
        repeat (7) begin
            @(negedge clk);
            chk("def_pause_x", int'(if_def.pixel_x), 100);
            chk("def_pause_strobes", int'(if_def.p_tick | if_def.line_start), 0);
        end
        if_def.en = 1'b1;
        @(negedge clk);
        chk("def_resume_last_clk_x", int'(if_def.pixel_x), 100);
        chk("def_resume_tick", int'(if_def.p_tick), 1);
        @(negedge clk);
        chk("def_resume_next_x", int'(if_def.pixel_x), 101);
        chk("def_resume_next_y", int'(if_def.pixel_y), 20);

        c = 0;
        while (!(if_def.pixel_x == 10'd700 && !if_def.p_tick) && c < 4000) begin @(negedge clk); c++; end
        chk("def_reach_700", int'(c < 4000), 1);
        chk("def_pre_reset_hsync", int'(if_def.hsync), 0);
        #2 rst_def = 1'b1;
        #1;
        chk("def_arst_hsync", int'(if_def.hsync), 1);
        chk("def_arst_vsync", int'(if_def.vsync), 1);
        chk("def_arst_x", int'(if_def.pixel_x), 0);
        chk("def_arst_y", int'(if_def.pixel_y), 0);
        chk("def_arst_video_on", int'(if_def.video_on), 1);
        repeat (2) @(negedge clk);
        rst_def = 1'b0;
        repeat (50) @(negedge clk);
    endtask

    task automatic run_sml();
        int c, pt_cnt;
        int fs_cyc[$];
        int ls_cyc[$];
        int fc_seq[$];
        int exp_fc[5];
        exp_fc = '{0, 1, 2, 3, 0};
        c = 0;
        while (!if_sml.p_tick && c < 10) begin @(negedge clk); c++; end
        chk("sml_first_tick_cycle", c, 0);
        pt_cnt = 0;
        for (int i = 0; i < 490; i++) begin
            if (if_sml.p_tick) pt_cnt++;
            if (if_sml.frame_start) fs_cyc.push_back(cyc);
            if (if_sml.line_start && ls_cyc.size() < 2) ls_cyc.push_back(cyc);
            if (if_sml.pixel_x == 4'd0 && if_sml.pixel_y == 4'd0) fc_seq.push_back(int'(if_sml.frame_count));
            @(negedge clk);
        end
        chk("sml_tick_every_clk", pt_cnt, 490);
        chk("sml_frame_start_count", fs_cyc.size(), 5);
        chk("sml_line_clks", ls_cyc[1] - ls_cyc[0], 14);
        chk("sml_frame_clks_first", fs_cyc[1] - fs_cyc[0], 98);
        chk("sml_frame_clks_last", fs_cyc[4] - fs_cyc[3], 98);
        chk("sml_fc_seq_len", fc_seq.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("sml_fc_at_origin_%0d", i), fc_seq[i], exp_fc[i]);
    endtask

    task automatic run_med();
        int c, vid, hs_cnt, hs_first, hs_last, vs_lines, vs_first, vs_last;
        c = 0;
        while (!if_med.p_tick && c < 10) begin @(negedge clk); c++; end
        chk("med_first_tick_cycle", c, 1);
        c = 0; vid = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
        vs_lines = 0; vs_first = -1; vs_last = -1;
        do begin
            if (if_med.p_tick && if_med.video_on) vid++;
            if (if_med.p_tick && if_med.hsync && if_med.pixel_y == 8'd0) begin
                if (hs_first < 0) hs_first = int'(if_med.pixel_x);
                hs_last = int'(if_med.pixel_x);
                hs_cnt++;
            end
            if (if_med.line_start && if_med.vsync) begin
                if (vs_first < 0) vs_first = int'(if_med.pixel_y);
                vs_last = int'(if_med.pixel_y);
                vs_lines++;
            end
            @(negedge clk); c++;
        end while (!if_med.frame_start && c < 20000);
        chk("med_frame_clks", c, 8960);
        chk("med_video_ticks", vid, 3072);
        chk("med_hsync_high_ticks", hs_cnt, 8);
        chk("med_hsync_first_x", hs_first, 68);
        chk("med_hsync_last_x", hs_last, 75);
        chk("med_vsync_lines", vs_lines, 2);
        chk("med_vsync_first_y", vs_first, 50);
        chk("med_vsync_last_y", vs_last, 51);
        chk("med_fc_after_frame", int'(if_med.frame_count), 1);

        c = 0;
        while (!(if_med.pixel_x == 8'd70 && if_med.pixel_y == 8'd51 && !if_med.p_tick) && c < 10000) begin
            @(negedge clk); c++;
        end
        chk("med_reach_70_51", int'(c < 10000), 1);
        chk("med_pre_reset_syncs", int'({if_med.hsync, if_med.vsync}), 3);
        #2 rst_med = 1'b1;
        #1;
        chk("med_arst_hsync", int'(if_med.hsync), 0);
        chk("med_arst_vsync", int'(if_med.vsync), 0);
        chk("med_arst_x", int'(if_med.pixel_x), 0);
        chk("med_arst_y", int'(if_med.pixel_y), 0);
        chk("med_arst_fc", int'(if_med.frame_count), 0);
        chk("med_arst_video_on", int'(if_med.video_on), 1);
        @(negedge clk);
        chk("med_rst_held_syncs", int'({if_med.hsync, if_med.vsync}), 0);
        @(negedge clk);
        rst_med = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        rst_def = 1'b1; rst_sml = 1'b1; rst_med = 1'b1;
        if_def.en = 1'b1; if_sml.en = 1'b1; if_med.en = 1'b1;
        repeat (3) @(negedge clk);
        chk("def_rst_hsync", int'(if_def.hsync), 1);
        chk("def_rst_vsync", int'(if_def.vsync), 1);
        chk("def_rst_video_on", int'(if_def.video_on), 1);
        chk("def_rst_tick", int'(if_def.p_tick), 0);
        chk("med_rst_hsync", int'(if_med.hsync), 0);
        chk("med_rst_vsync", int'(if_med.vsync), 0);
        rst_def = 1'b0; rst_sml = 1'b0; rst_med = 1'b0;
        fork
            run_def();
            run_sml();
            run_med();
        join
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=time_limit want=finish total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit reached");
    end

endmodule
